// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read-path blocks: FSM encoding, RRESP codes
// and a constant-evaluable clog2 for sizing index fields.
package axi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    DATA = ST_DATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, cyclic.
module rr_pick
  import axi_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int IDX_W   = clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int j;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_MST) j = j - NUM_MST;
      if (req[j]) begin
        idx   = IDX_W'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NUM_MST masters; one burst
// in flight at a time, with a sticky flag for beat counts that disagree with ARLEN.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter  int NUM_MST = 4,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int ID_W    = 4,
  localparam int IDX_W   = clog2(NUM_MST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MST-1:0]        m_arvalid,
  output logic [NUM_MST-1:0]        m_arready,
  input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MST*8-1:0]      m_arlen,
  input  logic [NUM_MST*ID_W-1:0]   m_arid,
  output logic [NUM_MST-1:0]        m_rvalid,
  input  logic [NUM_MST-1:0]        m_rready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [1:0]                m_rresp,
  output logic                      m_rlast,
  output logic [ID_W-1:0]           m_rid,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  output logic [ADDR_W-1:0]         s_araddr,
  output logic [7:0]                s_arlen,
  output logic [ID_W+IDX_W-1:0]     s_arid,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic [1:0]                s_rresp,
  input  logic                      s_rlast,
  input  logic [ID_W+IDX_W-1:0]     s_rid,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      len_err
);

  state_t state, state_n;

  logic [IDX_W-1:0] rr_ptr, pick_idx, ptr_next;
  logic             pick_vld, r_hs;
  logic [8:0]       beat_cnt;
  logic [7:0]       beat_cnt_max;
  logic             unused_rid;

  logic [NUM_MST-1:0][ADDR_W-1:0] araddr_v;
  logic [NUM_MST-1:0][7:0]        arlen_v;
  logic [NUM_MST-1:0][ID_W-1:0]   arid_v;

  assign araddr_v = m_araddr;
  assign arlen_v  = m_arlen;
  assign arid_v   = m_arid;

  rr_pick #(.NUM_MST(NUM_MST), .IDX_W(IDX_W)) u_pick (
    .req   (m_arvalid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (state)
      IDLE: if (pick_vld) state_n = ADDR;
      ADDR: begin
        s_arvalid            = 1'b1;
        m_arready[grant_idx] = s_arready;
        if (s_arready) state_n = DATA;
      end
      DATA: begin
        s_rready            = m_rready[grant_idx];
        m_rvalid[grant_idx] = s_rvalid;
        if (s_rvalid && m_rready[grant_idx] && s_rlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign r_hs     = s_rvalid & s_rready;
  assign ptr_next = (grant_idx == IDX_W'(NUM_MST - 1)) ? '0 : grant_idx + IDX_W'(1);

  // beat_cnt holds beats already accepted, so the expected RLAST beat sees
  // beat_cnt == ARLEN; an early match without RLAST means the slave overran.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_idx    <= '0;
      beat_cnt     <= '0;
      beat_cnt_max <= '0;
      len_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant_idx    <= pick_idx;
          beat_cnt_max <= arlen_v[pick_idx];
        end
        ADDR: if (s_arready) beat_cnt <= '0;
        DATA: if (r_hs) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (s_rlast) begin
            if (beat_cnt != {1'b0, beat_cnt_max}) len_err <= 1'b1;
            rr_ptr <= ptr_next;
          end else if (beat_cnt == {1'b0, beat_cnt_max}) begin
            len_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_araddr = araddr_v[grant_idx];
  assign s_arlen  = arlen_v[grant_idx];
  assign s_arid   = {grant_idx, arid_v[grant_idx]};

  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_rlast  = s_rlast;
  assign m_rid    = s_rid[ID_W-1:0];

  assign busy       = (state != IDLE);
  assign unused_rid = ^s_rid[ID_W+IDX_W-1:ID_W];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: task-driven masters and slave, R beats checked
// through an expected-beat queue popped by a negedge monitor.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int XW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr;
  logic [N*8-1:0]  m_arlen;
  logic [N*IW-1:0] m_arid;
  logic [DW-1:0]   m_rdata, s_rdata;
  logic [1:0]      m_rresp, s_rresp;
  logic            m_rlast, s_rlast;
  logic [IW-1:0]   m_rid;
  logic            s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0]   s_araddr;
  logic [7:0]      s_arlen;
  logic [IW+XW-1:0] s_arid, s_rid;
  logic [XW-1:0]   grant_idx;
  logic            busy, len_err;

  axi_rd_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .grant_idx(grant_idx), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] m;
    logic [DW-1:0] d;
    logic [1:0]    rs;
    logic          l;
    logic [IW-1:0] id;
  } r_t;

  r_t r_q[$];
  r_t mon_o, mon_e;
  int n_vec = 0, n_err = 0;
  int cyc = 0, last_rl = 0;
  logic exp_len_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (m_rvalid[i] && m_rready[i]) begin
          chk("r_q_nonempty", 64'(r_q.size() != 0), 64'd1);
          if (r_q.size() != 0) begin
            mon_e = r_q.pop_front();
            mon_o = '{m: XW'(i), d: m_rdata, rs: m_rresp, l: m_rlast, id: m_rid};
            chk("r_beat", 64'(mon_o), 64'(mon_e));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_len_err = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_len_err"}, 64'(len_err), 64'd0);
    chk({tag, "_grant"}, 64'(grant_idx), 64'd0);
    chk({tag, "_hs"}, 64'({s_arvalid, s_rready, m_arready, m_rvalid}), 64'd0);
  endtask

  task automatic issue(input int m, input logic [AW-1:0] a, input logic [7:0] l,
                       input logic [IW-1:0] id);
    logic ok = 1'b0;
    m_arvalid[m]         = 1'b1;
    m_araddr[m*AW +: AW] = a;
    m_arlen[m*8 +: 8]    = l;
    m_arid[m*IW +: IW]   = id;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m_arready[m]) begin ok = 1'b1; break; end
    end
    chk("ar_hs_wait", 64'(ok), 64'd1);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
  endtask

  // Slave side: accept the AR for master m, check it, return nb beats.
  task automatic serve(input int m, input logic [AW-1:0] a, input logic [7:0] l,
                       input logic [IW-1:0] id, input int nb, input int last_at,
                       input int gap, input int stall, input int abort_at);
    logic ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_arvalid) begin ok = 1'b1; break; end
    end
    chk("ar_wait", 64'(ok), 64'd1);
    if (gap != 0) chk("ar_gap", 64'(cyc - last_rl), 64'(gap));
    chk("ar_payload", 64'({s_araddr, s_arlen, s_arid}), 64'({a, l, XW'(m), id}));
    chk("ar_ready", 64'(m_arready), 64'(1 << m));
    @(posedge clk); #1;
    for (int k = 1; k <= nb; k++) begin
      s_rvalid = 1'b1;
      s_rdata  = $urandom;
      s_rlast  = (k == last_at);
      s_rresp  = s_rlast ? RESP_SLVERR : RESP_OKAY;
      s_rid    = {XW'(m), id};
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        exp_len_err = 1'b0;
        return;
      end
      if (k == 1 && stall > 0) begin
        m_rready[m] = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          chk("stall_s_rready", 64'(s_rready), 64'd0);
          chk("stall_m_rvalid", 64'(m_rvalid), 64'(1 << m));
          @(posedge clk); #1;
        end
        m_rready[m] = 1'b1;
      end
      r_q.push_back('{m: XW'(m), d: s_rdata, rs: s_rresp, l: s_rlast, id: id});
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (s_rready) begin ok = 1'b1; break; end
      end
      chk("r_wait", 64'(ok), 64'd1);
      if (s_rlast) last_rl = cyc;
      if (s_rlast ? (k != int'(l) + 1) : (k == int'(l) + 1)) exp_len_err = 1'b1;
      @(posedge clk); #1;
      chk("len_err", 64'(len_err), 64'(exp_len_err));
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arid = '0;
    m_rready = '1; s_arready = 1'b1;
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
    do_reset();
    chk_idle_outputs("reset");

    // single master, 4-beat burst
    fork
      issue(0, 32'h0000_1000, 8'd3, 4'h5);
      serve(0, 32'h0000_1000, 8'd3, 4'h5, 4, 4, 0, 0, 0);
    join
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_len_err", 64'(len_err), 64'd0);

    // pointer now at 1: master 1 ahead of master 0
    fork
      issue(0, 32'h0000_2000, 8'd0, 4'h1);
      issue(1, 32'h0001_2000, 8'd0, 4'h2);
      begin
        serve(1, 32'h0001_2000, 8'd0, 4'h2, 1, 1, 0, 0, 0);
        serve(0, 32'h0000_2000, 8'd0, 4'h1, 1, 1, 2, 0, 0);
      end
    join

    do_reset();
    fork
      issue(0, 32'hA000_0000, 8'd0, 4'h3);
      issue(1, 32'hA100_0000, 8'd0, 4'h4);
      issue(2, 32'hA200_0000, 8'd0, 4'h6);
      begin
        serve(0, 32'hA000_0000, 8'd0, 4'h3, 1, 1, 0, 0, 0);
        serve(1, 32'hA100_0000, 8'd0, 4'h4, 1, 1, 2, 0, 0);
        serve(2, 32'hA200_0000, 8'd0, 4'h6, 1, 1, 2, 0, 0);
      end
    join

    // wrap-around after master 3
    fork
      issue(3, 32'hB300_0000, 8'd1, 4'h7);
      serve(3, 32'hB300_0000, 8'd1, 4'h7, 2, 2, 0, 0, 0);
    join
    fork
      issue(3, 32'hB300_0100, 8'd0, 4'h8);
      issue(0, 32'hB000_0100, 8'd0, 4'h9);
      begin
        serve(0, 32'hB000_0100, 8'd0, 4'h9, 1, 1, 0, 0, 0);
        serve(3, 32'hB300_0100, 8'd0, 4'h8, 1, 1, 2, 0, 0);
      end
    join

    // backpressure, then same master regranted back-to-back
    fork
      begin
        issue(1, 32'hC100_0000, 8'd1, 4'hA);
        issue(1, 32'hC100_0040, 8'd2, 4'hB);
      end
      begin
        serve(1, 32'hC100_0000, 8'd1, 4'hA, 2, 2, 0, 3, 0);
        serve(1, 32'hC100_0040, 8'd2, 4'hB, 3, 3, 2, 0, 0);
      end
    join
    chk("pre_err_len_err", 64'(len_err), 64'd0);

    // slave overruns: RLAST on beat 3 of an ARLEN=1 burst
    fork
      issue(2, 32'hD200_0000, 8'd1, 4'hC);
      serve(2, 32'hD200_0000, 8'd1, 4'hC, 3, 3, 0, 0, 0);
    join
    chk("overrun_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("overrun_sticky", 64'(len_err), 64'd1);

    // reset mid-burst, then arbitration restarts from master 0
    fork
      issue(3, 32'hE300_0000, 8'd3, 4'hD);
      serve(3, 32'hE300_0000, 8'd3, 4'hD, 4, 4, 0, 0, 2);
    join
    chk_idle_outputs("abort");
    fork
      issue(0, 32'hF000_0000, 8'd0, 4'hE);
      issue(3, 32'hF300_0000, 8'd0, 4'hF);
      begin
        serve(0, 32'hF000_0000, 8'd0, 4'hE, 1, 1, 0, 0, 0);
        serve(3, 32'hF300_0000, 8'd0, 4'hF, 1, 1, 2, 0, 0);
      end
    join

    repeat (3) @(posedge clk);
    #1 chk("r_q_drained", 64'(r_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin arbiter that shares one AXI read port (AR + R channels) of the interconnect among NUM_MST read masters. It sits between the master-side read ports and the single slave read port inside axi_top. It grants one burst at a time: the grant is held from AR handshake until the R beat carrying RLAST. It also counts returned beats against ARLEN and flags length mismatches.

## Interface
- NUM_MST, 4, number of requesting masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, master-side ID width; slave-side ID is ID_W+IDX_W, where IDX_W = clog2(NUM_MST)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m_arvalid  in  NUM_MST  per-master AR valid
- m_arready  out  NUM_MST  per-master AR ready
- m_araddr  in  NUM_MST*ADDR_W  packed per-master address; master i occupies slice i
- m_arlen  in  NUM_MST*8  packed burst lengths (beats-1)
- m_arid  in  NUM_MST*ID_W  packed IDs
- m_rvalid  out  NUM_MST  per-master R valid
- m_rready  in  NUM_MST  per-master R ready
- m_rdata / m_rresp / m_rlast / m_rid  out  DATA_W / 2 / 1 / ID_W  broadcast R payload, qualified by m_rvalid
- s_arvalid / s_arready  out / in  1 / 1  slave AR handshake
- s_araddr / s_arlen / s_arid  out  ADDR_W / 8 / ID_W+IDX_W  slave AR payload
- s_rvalid / s_rready  in / out  1 / 1  slave R handshake
- s_rdata / s_rresp / s_rlast / s_rid  in  DATA_W / 2 / 1 / ID_W+IDX_W  slave R payload
- grant_idx  out  IDX_W  current owner
- busy  out  1  high in ADDR or DATA
- len_err  out  1  sticky; beat count did not match ARLEN+1

## Operation
- FSM states:
  - IDLE: if any m_arvalid is set, choose the first requester at or after rr_ptr (cyclic). Register it in grant_idx, latch its arlen into beat_cnt_max, and go to ADDR.
  - ADDR: s_arvalid=1. s_araddr and s_arlen come from the granted slice. s_arid = {grant_idx, m_arid[g]}. m_arready[g] = s_arready; all other m_arready bits are 0. On s_arvalid&s_arready, clear beat_cnt and go to DATA.
  - DATA: m_rvalid[g] = s_rvalid and s_rready = m_rready[g]; all other m_rvalid bits are 0. m_rid = s_rid[ID_W-1:0]. Each handshake increments beat_cnt (9 bits). On a handshake with s_rlast=1, return to IDLE and set rr_ptr = (g+1) mod NUM_MST.
- Length check:
  - On the RLAST beat, if beat_cnt != beat_cnt_max, set len_err.
  - On a beat where beat_cnt == beat_cnt_max but s_rlast=0, also set len_err. The FSM still waits for RLAST.
  - len_err clears only on rst.
- Boundary cases:
  - A master dropping arvalid in ADDR is an AXI violation. The grant is held anyway; this case is not checked.
  - rr_ptr wraps from NUM_MST-1 to 0.
  - A single requester is regranted back-to-back.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, busy=0, len_err=0, beat_cnt=0. All m_arready, m_rvalid, s_arvalid and s_rready are 0.
- rst mid-burst aborts to IDLE on the next edge. No completion beat is generated.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives s_arvalid=1 after edge N+1.
- All AR/R payload and handshake signals are combinational muxes from registered grant_idx/state. There is no R-path latency: 0 cycles slave→master.
- Between bursts there is a mandatory IDLE cycle, so the minimum gap between bursts is 2 cycles from RLAST handshake to the next s_arvalid.
- Backpressure: s_rready follows m_rready[g] in the same cycle. Data is never buffered.

## Structure
- Shared package axi_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2
  - the RRESP codes (OKAY=2'b00, SLVERR=2'b10)
  - the clog2 function
- One sub-module, rr_pick: combinational round-robin pick. Inputs are req[NUM_MST] and ptr. Outputs are idx and valid. The arbiter instantiates it once.

## Test plan
- Single master 0, ARLEN=3, slave returns 4 beats with RLAST on beat 4 → one AR with s_arid={0,id}; 4 beats reach master 0 only; len_err=0; rr_ptr=1.
- Masters 0,1,2 request simultaneously, each ARLEN=0 → grants in order 0,1,2; each s_arvalid assertion is ≥2 cycles after the previous RLAST.
- Master 3 granted, then masters 3 and 0 request again → next grant is 0 (wrap-around), then 3.
- DATA phase with m_rready[g] low for 3 cycles while s_rvalid=1 → s_rready=0 for those cycles; the beat is delivered once m_rready rises, with no loss or duplication.
- ARLEN=1, slave asserts RLAST on beat 3 → len_err=1 after the 2nd beat; returns to IDLE after the 3rd beat; len_err stays high.
- rst asserted for 1 cycle during beat 2 of a 4-beat burst → next cycle all outputs are at reset values, busy=0, and a new request is granted starting from master 0.
